// File: rtl/dif_butterfly_if.sv
// Handshake and data bundle between a DIF butterfly and its stage controller.
// master drives samples and accepts results; slave is the butterfly itself.
interface dif_butterfly_if #(
    parameter int DW = 24,
    parameter int TW = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] xp_real;
    logic signed [DW-1:0] xp_imag;
    logic signed [DW-1:0] xq_real;
    logic signed [DW-1:0] xq_imag;
    logic signed [TW-1:0] factor_real;
    logic signed [TW-1:0] factor_imag;
    logic                 inv;
    logic                 scale;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] yp_real;
    logic signed [DW-1:0] yp_imag;
    logic signed [DW-1:0] yq_real;
    logic signed [DW-1:0] yq_imag;
    logic                 ovf;
    logic                 ovf_clr;

    modport master (
        output in_valid, xp_real, xp_imag, xq_real, xq_imag,
               factor_real, factor_imag, inv, scale, out_ready, ovf_clr,
        input  in_ready, out_valid, yp_real, yp_imag, yq_real, yq_imag, ovf
    );

    modport slave (
        input  in_valid, xp_real, xp_imag, xq_real, xq_imag,
               factor_real, factor_imag, inv, scale, out_ready, ovf_clr,
        output in_ready, out_valid, yp_real, yp_imag, yq_real, yq_imag, ovf
    );
endinterface

// File: rtl/dif_butterfly.sv
// Radix-2 DIF butterfly: yp = xp + xq, yq = (xp - xq) * W, three-stage pipeline
// with a stallable valid/ready handshake, rounding, saturation and sticky overflow.
module dif_butterfly #(
    parameter int DW   = 24,
    parameter int TW   = 16,
    parameter int FRAC = 13
) (
    input logic            clk,
    input logic            rst,
    dif_butterfly_if.slave bus
);
    localparam int SW = DW + 1;
    localparam int WW = TW + 1;
    localparam int PW = DW + TW + 1;
    localparam int XW = SW + FRAC;
    localparam int RW = PW + 2;

    // Round half up by 2^(FRAC+sc), clip to DW bits; bit DW flags a clip.
    function automatic logic [DW:0] round_sat(input logic signed [RW-1:0] v, input logic sc);
        logic signed [RW-1:0] one_v;
        logic signed [RW-1:0] rnd_v;
        logic signed [RW-1:0] sh_v;
        logic signed [RW-1:0] max_v;
        logic signed [RW-1:0] min_v;
        logic [DW:0]          res_v;
        one_v = {{(RW-1){1'b0}}, 1'b1};
        max_v = {{(RW-DW+1){1'b0}}, {(DW-1){1'b1}}};
        min_v = {{(RW-DW+1){1'b1}}, {(DW-1){1'b0}}};
        if (sc) begin
            rnd_v = v + (one_v <<< (FRAC + 1 - 1));
            sh_v  = rnd_v >>> (FRAC + 1);
        end else begin
            rnd_v = v + (one_v <<< (FRAC - 1));
            sh_v  = rnd_v >>> FRAC;
        end
        if (sh_v > max_v) begin
            res_v = {1'b1, max_v[DW-1:0]};
        end else if (sh_v < min_v) begin
            res_v = {1'b1, min_v[DW-1:0]};
        end else begin
            res_v = {1'b0, sh_v[DW-1:0]};
        end
        return res_v;
    endfunction

    logic                 advance_s;
    logic                 s1_valid_q, s1_valid_d, s1_scale_q, s1_scale_d;
    logic signed [SW-1:0] sp_r_q, sp_r_d, sp_i_q, sp_i_d;
    logic signed [SW-1:0] dq_r_q, dq_r_d, dq_i_q, dq_i_d;
    logic signed [WW-1:0] wr_q, wr_d, wi_q, wi_d;
    logic signed [WW-1:0] wi_ext_s;
    logic                 s2_valid_q, s2_valid_d, s2_scale_q, s2_scale_d;
    logic signed [PW-1:0] p_rr_q, p_rr_d, p_ii_q, p_ii_d;
    logic signed [PW-1:0] p_ri_q, p_ri_d, p_ir_q, p_ir_d;
    logic signed [PW-1:0] dr_x_s, di_x_s, wr_x_s, wi_x_s;
    logic signed [XW-1:0] xs_r_q, xs_r_d, xs_i_q, xs_i_d;
    logic signed [RW-1:0] vp_r_s, vp_i_s, vq_r_s, vq_i_s;
    logic [DW:0]          rp_r_s, rp_i_s, rq_r_s, rq_i_s;
    logic                 clip_s;
    logic                 out_valid_q, out_valid_d, ovf_q, ovf_d;
    logic signed [DW-1:0] yp_real_q, yp_real_d, yp_imag_q, yp_imag_d;
    logic signed [DW-1:0] yq_real_q, yq_real_d, yq_imag_q, yq_imag_d;

    assign advance_s     = bus.out_ready | ~out_valid_q;
    assign bus.in_ready  = advance_s;
    assign bus.out_valid = out_valid_q;
    assign bus.yp_real   = yp_real_q;
    assign bus.yp_imag   = yp_imag_q;
    assign bus.yq_real   = yq_real_q;
    assign bus.yq_imag   = yq_imag_q;
    assign bus.ovf       = ovf_q;

    // Next-state values for all three stages and the sticky overflow flag.
    always_comb begin
        s1_valid_d = bus.in_valid;
        s1_scale_d = bus.scale;
        sp_r_d     = {bus.xp_real[DW-1], bus.xp_real} + {bus.xq_real[DW-1], bus.xq_real};
        sp_i_d     = {bus.xp_imag[DW-1], bus.xp_imag} + {bus.xq_imag[DW-1], bus.xq_imag};
        dq_r_d     = {bus.xp_real[DW-1], bus.xp_real} - {bus.xq_real[DW-1], bus.xq_real};
        dq_i_d     = {bus.xp_imag[DW-1], bus.xp_imag} - {bus.xq_imag[DW-1], bus.xq_imag};
        wr_d       = {bus.factor_real[TW-1], bus.factor_real};
        wi_ext_s   = {bus.factor_imag[TW-1], bus.factor_imag};
        // The extra twiddle bit keeps conj(-32768j) representable.
        if (bus.inv) begin
            wi_d = -wi_ext_s;
        end else begin
            wi_d = wi_ext_s;
        end

        dr_x_s     = {{(PW-SW){dq_r_q[SW-1]}}, dq_r_q};
        di_x_s     = {{(PW-SW){dq_i_q[SW-1]}}, dq_i_q};
        wr_x_s     = {{(PW-WW){wr_q[WW-1]}}, wr_q};
        wi_x_s     = {{(PW-WW){wi_q[WW-1]}}, wi_q};
        p_rr_d     = dr_x_s * wr_x_s;
        p_ii_d     = di_x_s * wi_x_s;
        p_ri_d     = dr_x_s * wi_x_s;
        p_ir_d     = di_x_s * wr_x_s;
        xs_r_d     = {sp_r_q, {FRAC{1'b0}}};
        xs_i_d     = {sp_i_q, {FRAC{1'b0}}};
        s2_valid_d = s1_valid_q;
        s2_scale_d = s1_scale_q;

        vq_r_s = {{2{p_rr_q[PW-1]}}, p_rr_q} - {{2{p_ii_q[PW-1]}}, p_ii_q};
        vq_i_s = {{2{p_ri_q[PW-1]}}, p_ri_q} + {{2{p_ir_q[PW-1]}}, p_ir_q};
        vp_r_s = {{(RW-XW){xs_r_q[XW-1]}}, xs_r_q};
        vp_i_s = {{(RW-XW){xs_i_q[XW-1]}}, xs_i_q};
        rp_r_s = round_sat(vp_r_s, s2_scale_q);
        rp_i_s = round_sat(vp_i_s, s2_scale_q);
        rq_r_s = round_sat(vq_r_s, s2_scale_q);
        rq_i_s = round_sat(vq_i_s, s2_scale_q);
        clip_s = rp_r_s[DW] | rp_i_s[DW] | rq_r_s[DW] | rq_i_s[DW];
        yp_real_d   = rp_r_s[DW-1:0];
        yp_imag_d   = rp_i_s[DW-1:0];
        yq_real_d   = rq_r_s[DW-1:0];
        yq_imag_d   = rq_i_s[DW-1:0];
        out_valid_d = s2_valid_q;

        if (bus.ovf_clr) begin
            ovf_d = 1'b0;
        end else if (advance_s && s2_valid_q && clip_s) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Pipeline registers: cleared by reset, shift together only on advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_scale_q  <= 1'b0;
            sp_r_q      <= {SW{1'b0}};
            sp_i_q      <= {SW{1'b0}};
            dq_r_q      <= {SW{1'b0}};
            dq_i_q      <= {SW{1'b0}};
            wr_q        <= {WW{1'b0}};
            wi_q        <= {WW{1'b0}};
            s2_valid_q  <= 1'b0;
            s2_scale_q  <= 1'b0;
            p_rr_q      <= {PW{1'b0}};
            p_ii_q      <= {PW{1'b0}};
            p_ri_q      <= {PW{1'b0}};
            p_ir_q      <= {PW{1'b0}};
            xs_r_q      <= {XW{1'b0}};
            xs_i_q      <= {XW{1'b0}};
            out_valid_q <= 1'b0;
            yp_real_q   <= {DW{1'b0}};
            yp_imag_q   <= {DW{1'b0}};
            yq_real_q   <= {DW{1'b0}};
            yq_imag_q   <= {DW{1'b0}};
            ovf_q       <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            if (advance_s) begin
                s1_valid_q  <= s1_valid_d;
                s1_scale_q  <= s1_scale_d;
                sp_r_q      <= sp_r_d;
                sp_i_q      <= sp_i_d;
                dq_r_q      <= dq_r_d;
                dq_i_q      <= dq_i_d;
                wr_q        <= wr_d;
                wi_q        <= wi_d;
                s2_valid_q  <= s2_valid_d;
                s2_scale_q  <= s2_scale_d;
                p_rr_q      <= p_rr_d;
                p_ii_q      <= p_ii_d;
                p_ri_q      <= p_ri_d;
                p_ir_q      <= p_ir_d;
                xs_r_q      <= xs_r_d;
                xs_i_q      <= xs_i_d;
                out_valid_q <= out_valid_d;
                yp_real_q   <= yp_real_d;
                yp_imag_q   <= yp_imag_d;
                yq_real_q   <= yq_real_d;
                yq_imag_q   <= yq_imag_d;
            end
        end
    end
endmodule

// File: tb/tb_dif_butterfly.sv
// Scoreboard bench for dif_butterfly: directed corner cases plus a randomized
// stream with random back-pressure, checked against an arithmetic reference model.
module tb_dif_butterfly;
    localparam int DW   = 24;
    localparam int TW   = 16;
    localparam int FRAC = 13;
    localparam longint YMAX = 64'sd8388607;
    localparam longint YMIN = -64'sd8388608;

    typedef struct {
        longint yp_r;
        longint yp_i;
        longint yq_r;
        longint yq_i;
        bit     clip;
        bit     chk_lat;
        int     acc_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    dif_butterfly_if #(.DW(DW), .TW(TW)) bus ();
    dif_butterfly #(.DW(DW), .TW(TW), .FRAC(FRAC)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    exp_t   sb_q[$];
    int     errors = 0;
    int     checks = 0;
    int     cyc = 0;
    int     pop_cnt = 0;
    int     first_cyc = 0;
    bit     lat_chk = 1'b0;
    bit     exp_ovf = 1'b0;
    bit     rst_prev = 1'b1;
    bit     clr_prev = 1'b0;
    bit     new_item = 1'b1;
    bit     rand_done = 1'b0;
    longint last_yp_r = 0, last_yp_i = 0, last_yq_r = 0, last_yq_i = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint rnd_sat(input longint v, input bit sc, inout bit clip);
        int     sh;
        longint r;
        sh = FRAC + int'(sc);
        r  = (v + (64'sd1 <<< (sh - 1))) >>> sh;
        if (r > YMAX) begin
            r = YMAX;
            clip = 1'b1;
        end else if (r < YMIN) begin
            r = YMIN;
            clip = 1'b1;
        end
        return r;
    endfunction

    function automatic exp_t model(input longint xpr, input longint xpi, input longint xqr,
                                   input longint xqi, input longint fr, input longint fi,
                                   input bit iv, input bit sc);
        exp_t   e;
        bit     c;
        longint unity, wi, dr, di;
        unity = 64'sd1 <<< FRAC;
        wi    = iv ? -fi : fi;
        dr    = xpr - xqr;
        di    = xpi - xqi;
        c     = 1'b0;
        e.yp_r = rnd_sat((xpr + xqr) * unity, sc, c);
        e.yp_i = rnd_sat((xpi + xqi) * unity, sc, c);
        e.yq_r = rnd_sat(dr * fr - di * wi, sc, c);
        e.yq_i = rnd_sat(dr * wi + di * fr, sc, c);
        e.clip = c;
        e.chk_lat = 1'b0;
        e.acc_cyc = 0;
        return e;
    endfunction

    // Stimulus side of the scoreboard: every accepted sample queues its expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.in_valid && bus.in_ready) begin
            e = model(longint'(bus.xp_real), longint'(bus.xp_imag), longint'(bus.xq_real),
                      longint'(bus.xq_imag), longint'(bus.factor_real), longint'(bus.factor_imag),
                      bus.inv, bus.scale);
            e.chk_lat = lat_chk;
            e.acc_cyc = cyc;
            sb_q.push_back(e);
        end
    end

    // Monitor: pops on each output transfer and tracks the expected sticky flag.
    always @(negedge clk) begin
        exp_t e;
        if (rst_prev || clr_prev) begin
            exp_ovf = 1'b0;
        end else if (bus.out_valid && new_item && sb_q.size() > 0) begin
            if (sb_q[0].clip) exp_ovf = 1'b1;
        end
        chk("ovf", longint'(bus.ovf), longint'(exp_ovf));
        if (bus.out_valid && new_item) first_cyc = cyc;
        if (rst) begin
            sb_q.delete();
            new_item = 1'b1;
        end else begin
            if (bus.out_ready) chk("in_ready_with_out_ready", longint'(bus.in_ready), 64'sd1);
            if (bus.out_valid && bus.out_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_output: got out_valid=1, expected no pending sample");
                end else begin
                    e = sb_q.pop_front();
                    pop_cnt++;
                    last_yp_r = longint'(bus.yp_real);
                    last_yp_i = longint'(bus.yp_imag);
                    last_yq_r = longint'(bus.yq_real);
                    last_yq_i = longint'(bus.yq_imag);
                    chk("yp_real", last_yp_r, e.yp_r);
                    chk("yp_imag", last_yp_i, e.yp_i);
                    chk("yq_real", last_yq_r, e.yq_r);
                    chk("yq_imag", last_yq_i, e.yq_i);
                    if (e.chk_lat) chk("latency", longint'(first_cyc - e.acc_cyc), 64'sd3);
                end
                new_item = 1'b1;
            end else if (bus.out_valid) begin
                new_item = 1'b0;
            end else begin
                new_item = 1'b1;
            end
        end
        rst_prev = rst;
        clr_prev = bus.ovf_clr;
    end

    task automatic send(input longint xpr, input longint xpi, input longint xqr, input longint xqi,
                        input longint fr, input longint fi, input bit iv, input bit sc);
        int n;
        bit ok;
        n  = 0;
        ok = 1'b0;
        bus.in_valid    = 1'b1;
        bus.xp_real     = xpr[DW-1:0];
        bus.xp_imag     = xpi[DW-1:0];
        bus.xq_real     = xqr[DW-1:0];
        bus.xq_imag     = xqi[DW-1:0];
        bus.factor_real = fr[TW-1:0];
        bus.factor_imag = fi[TW-1:0];
        bus.inv         = iv;
        bus.scale       = sc;
        do begin
            @(negedge clk);
            ok = bus.in_ready && !rst;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 100);
        if (!ok) chk("send_timeout", 64'sd0, 64'sd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || bus.out_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("drain_timeout", 64'sd0, 64'sd1);
        @(posedge clk);
        #1;
    endtask

    function automatic longint rand_data();
        logic [31:0]          r;
        logic signed [DW-1:0] v;
        r = $urandom;
        v = r[DW-1:0];
        if (r[31:30] == 2'd0) return longint'(v);
        return longint'($urandom_range(0, 4000)) - 64'sd2000;
    endfunction

    function automatic longint rand_tw();
        logic [31:0]          r;
        logic signed [TW-1:0] w;
        r = $urandom;
        w = r[TW-1:0];
        if (r[31:29] == 3'd0) return longint'(w);
        return longint'($urandom_range(0, 16384)) - 64'sd8192;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected end of run");
        $fatal(1, "watchdog");
    end

    initial begin
        int pc0;
        bus.in_valid = 1'b0;
        bus.xp_real = '0; bus.xp_imag = '0; bus.xq_real = '0; bus.xq_imag = '0;
        bus.factor_real = '0; bus.factor_imag = '0;
        bus.inv = 1'b0; bus.scale = 1'b0; bus.out_ready = 1'b1; bus.ovf_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_out_valid", longint'(bus.out_valid), 64'sd0);
        chk("reset_ovf", longint'(bus.ovf), 64'sd0);
        chk("reset_in_ready", longint'(bus.in_ready), 64'sd1);
        chk("reset_yp_real", longint'(bus.yp_real), 64'sd0);

        lat_chk = 1'b1;
        send(1000, 0, 200, 0, 8192, 0, 1'b0, 1'b0);
        drain();
        chk("t1_yp_r", last_yp_r, 1200); chk("t1_yq_r", last_yq_r, 800); chk("t1_yq_i", last_yq_i, 0);

        send(0, 0, 100, 0, 0, -8192, 1'b0, 1'b0);
        drain();
        chk("t2_yq_i", last_yq_i, 100); chk("t2_yq_r", last_yq_r, 0); chk("t2_yp_r", last_yp_r, 100);
        send(0, 0, 100, 0, 0, -8192, 1'b1, 1'b0);
        drain();
        chk("t2_inv_yq_i", last_yq_i, -100); chk("t2_inv_yp_r", last_yp_r, 100);

        send(8388607, 0, 8388607, 0, 8192, 0, 1'b0, 1'b0);
        drain();
        chk("t3_sat_yp_r", last_yp_r, 8388607); chk("t3_ovf_set", longint'(bus.ovf), 64'sd1);
        bus.ovf_clr = 1'b1;
        @(posedge clk); #1;
        bus.ovf_clr = 1'b0;
        chk("t3_ovf_clr", longint'(bus.ovf), 64'sd0);
        send(8388607, 0, 8388607, 0, 8192, 0, 1'b0, 1'b1);
        drain();
        chk("t3_scaled_yp_r", last_yp_r, 8388607); chk("t3_ovf_stays", longint'(bus.ovf), 64'sd0);

        send(3, 0, 0, 0, 8192, 0, 1'b0, 1'b1);
        drain();
        chk("t4_pos_yp", last_yp_r, 2); chk("t4_pos_yq", last_yq_r, 2);
        send(-3, 0, 0, 0, 8192, 0, 1'b0, 1'b1);
        drain();
        chk("t4_neg_yp", last_yp_r, -1); chk("t4_neg_yq", last_yq_r, -1);
        send(5000, -7, 1000, 3, -8192, 0, 1'b0, 1'b0);
        drain();
        chk("wm1_yq_r", last_yq_r, -4000); chk("wm1_yq_i", last_yq_i, 10);

        lat_chk = 1'b0;
        pc0 = pop_cnt;
        fork
            begin
                for (int i = 0; i < 8; i++) send(i * 100 + 1, -i, i * 7, 3, 5793, -5793, 1'b0, 1'b0);
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    chk("t5_in_ready_stall", longint'(bus.in_ready), 64'sd0);
                end
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();
        chk("t5_count", longint'(pop_cnt - pc0), 64'sd8);

        lat_chk = 1'b1;
        send(8388607, 0, 8388607, 0, 8192, 0, 1'b0, 1'b0);
        drain();
        chk("t6_ovf_before", longint'(bus.ovf), 64'sd1);
        pc0 = pop_cnt;
        send(11, 0, 1, 0, 8192, 0, 1'b0, 1'b0);
        send(22, 0, 2, 0, 8192, 0, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t6_out_valid", longint'(bus.out_valid), 64'sd0);
        chk("t6_ovf", longint'(bus.ovf), 64'sd0);
        chk("t6_in_ready", longint'(bus.in_ready), 64'sd1);
        send(500, 0, 100, 0, 8192, 0, 1'b0, 1'b0);
        drain();
        chk("t6_count", longint'(pop_cnt - pc0), 64'sd1);
        chk("t6_yp_r", last_yp_r, 600);

        lat_chk = 1'b0;
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    bus.ovf_clr = ($urandom_range(0, 19) == 0);
                    send(rand_data(), rand_data(), rand_data(), rand_data(), rand_tw(), rand_tw(),
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                    bus.ovf_clr = 1'b0;
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk); #1;
                    end
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();
        chk("final_queue_empty", longint'(sb_q.size()), 64'sd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
